// File: rtl/if_prefetch_buf.sv
// Instruction prefetch queue between the variable-latency instruction memory and IF/ID.
// Keeps fetches in flight, buffers returned words with PC+1 and drops wrong-path words by count.
module if_prefetch_buf #(
    parameter int          DEPTH    = 4,
    parameter logic [29:0] RESET_PC = 30'h00C00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [29:0] redirect_pc,
    input  logic        deq_en,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [29:0] out_pc_add_one,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [29:0]   fetchPcReg, fetchPcNext;
    logic [29:0]   rspPcReg, rspPcNext;
    logic [CW-1:0] outstandingReg, outstandingNext;
    logic [CW-1:0] discardReg, discardNext;
    logic [CW-1:0] occReg, occNext;
    logic [AW-1:0] rdPtrReg, rdPtrNext;
    logic [AW-1:0] wrPtrReg, wrPtrNext;
    logic          outValidReg, outValidNext;
    logic [31:0]   outInstrReg, outInstrNext;
    logic [29:0]   outPcReg, outPcNext;

    logic [31:0]   instrMem [DEPTH];
    logic [29:0]   pcMem    [DEPTH];

    logic [CW:0]   inUse;
    logic          credit;
    logic          grant;
    logic          push;
    logic          pop;
    logic          headIsPush;

    // Words already buffered plus live (not-to-be-dropped) fetches must fit in the queue.
    assign inUse  = {1'b0, occReg} + {1'b0, outstandingReg} - {1'b0, discardReg};
    assign credit = (inUse < (CW+1)'(DEPTH));

    assign imem_req  = credit & ~redirect_valid & ~rst;
    assign imem_addr = fetchPcReg;

    assign grant = imem_req & imem_gnt;
    assign push  = imem_rvalid & (discardReg == CW'(0)) & ~redirect_valid;
    assign pop   = outValidReg & deq_en & ~redirect_valid;

    // A word pushed into a queue that is (or becomes) empty this cycle is the next head.
    assign headIsPush = push & ((occReg - CW'(pop)) == CW'(0));

    always_comb begin
        fetchPcNext     = fetchPcReg;
        rspPcNext       = rspPcReg;
        outstandingNext = outstandingReg + CW'(grant) - CW'(imem_rvalid);
        discardNext     = discardReg;
        occNext         = occReg;
        rdPtrNext       = rdPtrReg;
        wrPtrNext       = wrPtrReg;

        if (redirect_valid) begin
            fetchPcNext = redirect_pc;
            rspPcNext   = redirect_pc;
            discardNext = outstandingReg - CW'(imem_rvalid);
            occNext     = CW'(0);
            wrPtrNext   = rdPtrReg;
        end else begin
            if (grant) begin
                fetchPcNext = fetchPcReg + 30'd1;
            end
            if (imem_rvalid && (discardReg != CW'(0))) begin
                discardNext = discardReg - CW'(1);
            end
            if (push) begin
                rspPcNext = rspPcReg + 30'd1;
                wrPtrNext = wrPtrReg + AW'(1);
            end
            if (pop) begin
                rdPtrNext = rdPtrReg + AW'(1);
            end
            occNext = occReg + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        outValidNext = (occNext != CW'(0));
        outInstrNext = outInstrReg;
        outPcNext    = outPcReg;
        if (outValidNext) begin
            if (headIsPush) begin
                outInstrNext = imem_rdata;
                outPcNext    = rspPcReg + 30'd1;
            end else begin
                outInstrNext = instrMem[rdPtrNext];
                outPcNext    = pcMem[rdPtrNext];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPcReg     <= RESET_PC;
            rspPcReg       <= RESET_PC;
            outstandingReg <= '0;
            discardReg     <= '0;
            occReg         <= '0;
            rdPtrReg       <= '0;
            wrPtrReg       <= '0;
            outValidReg    <= 1'b0;
            outInstrReg    <= '0;
            outPcReg       <= '0;
        end else begin
            fetchPcReg     <= fetchPcNext;
            rspPcReg       <= rspPcNext;
            outstandingReg <= outstandingNext;
            discardReg     <= discardNext;
            occReg         <= occNext;
            rdPtrReg       <= rdPtrNext;
            wrPtrReg       <= wrPtrNext;
            outValidReg    <= outValidNext;
            outInstrReg    <= outInstrNext;
            outPcReg       <= outPcNext;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            instrMem[wrPtrReg] <= imem_rdata;
            pcMem[wrPtrReg]    <= rspPcReg + 30'd1;
        end
    end

    assign out_valid      = outValidReg;
    assign out_instr      = outInstrReg;
    assign out_pc_add_one = outPcReg;

    noOverflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (occReg == CW'(DEPTH))));

endmodule

// File: tb/tb_if_prefetch_buf.sv
// Bench for if_prefetch_buf: in-order random-latency memory model plus a path-level
// reference (next fetch address, next instruction address the core should receive).
module tb_if_prefetch_buf;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [29:0] redirect_pc = '0;
    logic        deq_en = 1'b0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [29:0] out_pc_add_one;
    logic        imem_req;
    logic [29:0] imem_addr;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lastReady = -1;
    int gntPct = 100;
    int latMin = 1;
    int latMax = 1;

    typedef struct {
        int          ready;
        logic [29:0] addr;
    } memTxn_t;
    memTxn_t memQ[$];

    logic [29:0] expFetch;
    logic [29:0] expPc;
    logic        gntSeen, popSeen, reqSeen;
    logic [29:0] reqAddr, popPcp1;
    logic [31:0] popInstr;

    if_prefetch_buf dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq_en         (deq_en),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc_add_one (out_pc_add_one),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [29:0] a);
        return {a, 2'b01} ^ 32'hC3A5_5A3C;
    endfunction

    // One clock cycle: memory drives, outputs are sampled before the edge, model advances.
    task automatic step();
        memTxn_t t;
        int      r;
        imem_gnt = ($urandom_range(99) < gntPct);
        if (memQ.size() > 0 && memQ[0].ready <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memWord(memQ[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        reqSeen  = imem_req;
        reqAddr  = imem_addr;
        gntSeen  = imem_req & imem_gnt;
        popSeen  = out_valid & deq_en & ~redirect_valid;
        popPcp1  = out_pc_add_one;
        popInstr = out_instr;
        @(posedge clk);
        if (gntSeen) begin
            r = cyc + $urandom_range(latMax, latMin);
            if (r <= lastReady) r = lastReady + 1;
            t.ready = r;
            t.addr  = reqAddr;
            memQ.push_back(t);
            lastReady = r;
        end
        if (imem_rvalid) void'(memQ.pop_front());
        @(negedge clk);
        if (popSeen) $display("cyc %0d deq pc+1=%h instr=%h", cyc, popPcp1, popInstr);
        cyc++;
    endtask

    task automatic test_reset();
        int firstPop = -1;
        int gaps = 0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
        total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", out_instr); end
        total++; if (out_pc_add_one !== 30'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", out_pc_add_one); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", imem_req); end
        gntPct = 100; latMin = 1; latMax = 1; deq_en = 1'b1;
        expFetch = 30'h00C00; expPc = 30'h00C00;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (gntSeen) begin
                total++;
                if (reqAddr !== expFetch) begin bad++; $display("FAIL t1_addr got=%h want=%h", reqAddr, expFetch); end
                expFetch = expFetch + 30'd1;
            end
            if (popSeen) begin
                total++;
                if (popPcp1 !== expPc + 30'd1 || popInstr !== memWord(expPc)) begin
                    bad++; $display("FAIL t1_deq got=%h/%h want=%h/%h", popPcp1, popInstr, expPc + 30'd1, memWord(expPc));
                end
                expPc = expPc + 30'd1;
                if (firstPop < 0) firstPop = i;
            end else if (firstPop >= 0) begin
                gaps++;
            end
        end
        total++; if (firstPop != 2) begin bad++; $display("FAIL t1_latency got=%0d want=2", firstPop); end
        total++; if (gaps != 0) begin bad++; $display("FAIL t1_gaps got=%0d want=0", gaps); end
    endtask

    task automatic test_stall();
        int pops = 0;
        int gnts = 0;
        deq_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (gntSeen) begin
                total++;
                if (reqAddr !== expFetch) begin bad++; $display("FAIL t2_addr got=%h want=%h", reqAddr, expFetch); end
                expFetch = expFetch + 30'd1;
            end
            total++;
            if (out_valid !== 1'b1 || out_pc_add_one !== expPc + 30'd1) begin
                bad++; $display("FAIL t2_hold got=%b/%h want=1/%h", out_valid, out_pc_add_one, expPc + 30'd1);
            end
        end
        total++; if (reqSeen !== 1'b0) begin bad++; $display("FAIL t2_req got=%b want=0", reqSeen); end
        total++; if (expFetch - expPc !== 30'd4 || memQ.size() != 0) begin
            bad++; $display("FAIL t2_fill got=%0d/%0d want=4/0", expFetch - expPc, memQ.size());
        end
        deq_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (gntSeen) begin
                total++;
                if (reqAddr !== expFetch) begin bad++; $display("FAIL t2_addr got=%h want=%h", reqAddr, expFetch); end
                expFetch = expFetch + 30'd1;
                gnts++;
            end
            if (popSeen) begin
                total++;
                if (popPcp1 !== expPc + 30'd1 || popInstr !== memWord(expPc)) begin
                    bad++; $display("FAIL t2_deq got=%h/%h want=%h/%h", popPcp1, popInstr, expPc + 30'd1, memWord(expPc));
                end
                expPc = expPc + 30'd1;
                pops++;
            end
        end
        total++; if (pops < 4 || gnts == 0) begin bad++; $display("FAIL t2_resume got=%0d/%0d want>=4/>0", pops, gnts); end
    endtask

    // Shared redirect stimulus; checks of the redirect cycle itself are inline here.
    task automatic do_redirect(input logic [29:0] target, input string tag);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
        total++; if (reqSeen !== 1'b0) begin bad++; $display("FAIL %s_redir_req got=%b want=0", tag, reqSeen); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_flush got=%b want=0", tag, out_valid); end
        expFetch = target;
        expPc    = target;
    endtask

    task automatic test_redirect();
        bit found = 0;
        int pops = 0;
        latMin = 3; latMax = 3; gntPct = 100; deq_en = 1'b1;
        for (int i = 0; i < 30 && !found; i++) begin
            if (memQ.size() == 3) begin
                found = 1;
            end else begin
                step();
                if (gntSeen) begin
                    total++;
                    if (reqAddr !== expFetch) begin bad++; $display("FAIL t3_addr got=%h want=%h", reqAddr, expFetch); end
                    expFetch = expFetch + 30'd1;
                end
                if (popSeen) begin
                    total++;
                    if (popPcp1 !== expPc + 30'd1 || popInstr !== memWord(expPc)) begin
                        bad++; $display("FAIL t3_deq got=%h/%h want=%h/%h", popPcp1, popInstr, expPc + 30'd1, memWord(expPc));
                    end
                    expPc = expPc + 30'd1;
                end
            end
        end
        total++; if (!found) begin bad++; $display("FAIL t3_setup got=%0d want=3 outstanding", memQ.size()); end
        do_redirect(30'h0001000, "t3");
        for (int i = 0; i < 20; i++) begin
            step();
            if (gntSeen) begin
                total++;
                if (reqAddr !== expFetch) begin bad++; $display("FAIL t3_addr got=%h want=%h", reqAddr, expFetch); end
                expFetch = expFetch + 30'd1;
            end
            if (popSeen) begin
                total++;
                if (pops == 0 && popPcp1 !== 30'h0001001) begin bad++; $display("FAIL t3_first got=%h want=1001", popPcp1); end
                if (popPcp1 !== expPc + 30'd1 || popInstr !== memWord(expPc)) begin
                    bad++; $display("FAIL t3_deq got=%h/%h want=%h/%h", popPcp1, popInstr, expPc + 30'd1, memWord(expPc));
                end
                expPc = expPc + 30'd1;
                pops++;
            end
        end
        total++; if (pops < 5) begin bad++; $display("FAIL t3_progress got=%0d want>=5", pops); end
    endtask

    task automatic test_redirect_rsp();
        bit found = 0;
        int pops = 0;
        logic [29:0] target;
        latMin = 2; latMax = 2; gntPct = 100; deq_en = 1'b1;
        for (int i = 0; i < 30 && !found; i++) begin
            if (memQ.size() > 0 && memQ[0].ready <= cyc && out_valid === 1'b1) begin
                found = 1;
            end else begin
                step();
                if (gntSeen) begin
                    total++;
                    if (reqAddr !== expFetch) begin bad++; $display("FAIL t4_addr got=%h want=%h", reqAddr, expFetch); end
                    expFetch = expFetch + 30'd1;
                end
                if (popSeen) begin
                    total++;
                    if (popPcp1 !== expPc + 30'd1 || popInstr !== memWord(expPc)) begin
                        bad++; $display("FAIL t4_deq got=%h/%h want=%h/%h", popPcp1, popInstr, expPc + 30'd1, memWord(expPc));
                    end
                    expPc = expPc + 30'd1;
                end
            end
        end
        total++; if (!found) begin bad++; $display("FAIL t4_setup no rvalid with out_valid"); end
        target = 30'($urandom);
        do_redirect(target, "t4");
        for (int i = 0; i < 20; i++) begin
            step();
            if (gntSeen) begin
                total++;
                if (reqAddr !== expFetch) begin bad++; $display("FAIL t4_addr got=%h want=%h", reqAddr, expFetch); end
                expFetch = expFetch + 30'd1;
            end
            if (popSeen) begin
                total++;
                if (popPcp1 !== expPc + 30'd1 || popInstr !== memWord(expPc)) begin
                    bad++; $display("FAIL t4_deq got=%h/%h want=%h/%h", popPcp1, popInstr, expPc + 30'd1, memWord(expPc));
                end
                expPc = expPc + 30'd1;
                pops++;
            end
        end
        total++; if (pops < 5) begin bad++; $display("FAIL t4_progress got=%0d want>=5", pops); end
    endtask

    task automatic test_wrap();
        int pops = 0;
        int gnts = 0;
        latMin = 1; latMax = 1; gntPct = 100; deq_en = 1'b1;
        do_redirect(30'h3FFFFFFF, "t5");
        for (int i = 0; i < 12; i++) begin
            step();
            if (gntSeen) begin
                total++;
                if (gnts == 1 && reqAddr !== 30'h0) begin bad++; $display("FAIL t5_addr_wrap got=%h want=0", reqAddr); end
                if (reqAddr !== expFetch) begin bad++; $display("FAIL t5_addr got=%h want=%h", reqAddr, expFetch); end
                expFetch = expFetch + 30'd1;
                gnts++;
            end
            if (popSeen) begin
                total++;
                if (pops == 0 && popPcp1 !== 30'h0) begin bad++; $display("FAIL t5_pc0 got=%h want=0", popPcp1); end
                if (pops == 1 && popPcp1 !== 30'h1) begin bad++; $display("FAIL t5_pc1 got=%h want=1", popPcp1); end
                if (popPcp1 !== expPc + 30'd1 || popInstr !== memWord(expPc)) begin
                    bad++; $display("FAIL t5_deq got=%h/%h want=%h/%h", popPcp1, popInstr, expPc + 30'd1, memWord(expPc));
                end
                expPc = expPc + 30'd1;
                pops++;
            end
        end
        total++; if (pops < 5) begin bad++; $display("FAIL t5_progress got=%0d want>=5", pops); end
    endtask

    task automatic test_async_reset();
        bit found = 0;
        int pops = 0;
        latMin = 3; latMax = 3; gntPct = 100; deq_en = 1'b1;
        do_redirect(30'h0002000, "t6");
        deq_en = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (memQ.size() == 2 && out_valid === 1'b1) found = 1;
            else step();
        end
        total++; if (!found) begin bad++; $display("FAIL t6_setup not reached"); end
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t6_valid got=%b want=0", out_valid); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL t6_req got=%b want=0", imem_req); end
        memQ.delete();
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        cyc += 2;
        lastReady = cyc;
        rst = 1'b0;
        deq_en = 1'b1;
        expFetch = 30'h00C00; expPc = 30'h00C00;
        for (int i = 0; i < 20; i++) begin
            step();
            if (gntSeen) begin
                total++;
                if (reqAddr !== expFetch) begin bad++; $display("FAIL t6_addr got=%h want=%h", reqAddr, expFetch); end
                expFetch = expFetch + 30'd1;
            end
            if (popSeen) begin
                total++;
                if (popPcp1 !== expPc + 30'd1 || popInstr !== memWord(expPc)) begin
                    bad++; $display("FAIL t6_deq got=%h/%h want=%h/%h", popPcp1, popInstr, expPc + 30'd1, memWord(expPc));
                end
                expPc = expPc + 30'd1;
                pops++;
            end
        end
        total++; if (pops < 5) begin bad++; $display("FAIL t6_progress got=%0d want>=5", pops); end
    endtask

    task automatic test_random();
        int pops = 0;
        logic prevReq = 1'b0;
        logic prevGnt = 1'b0;
        logic [29:0] prevAddr = '0;
        gntPct = 60; latMin = 1; latMax = 4;
        for (int i = 0; i < 400; i++) begin
            deq_en = ($urandom_range(99) < 70);
            if ($urandom_range(99) < 5) begin
                do_redirect(30'($urandom), "rnd");
                prevReq = 1'b0;
            end else begin
                step();
                if (prevReq && !prevGnt) begin
                    total++;
                    if (reqSeen !== 1'b1 || reqAddr !== prevAddr) begin
                        bad++; $display("FAIL rnd_stable got=%b/%h want=1/%h", reqSeen, reqAddr, prevAddr);
                    end
                end
                if (gntSeen) begin
                    total++;
                    if (reqAddr !== expFetch) begin bad++; $display("FAIL rnd_addr got=%h want=%h", reqAddr, expFetch); end
                    expFetch = expFetch + 30'd1;
                end
                if (popSeen) begin
                    total++;
                    if (popPcp1 !== expPc + 30'd1 || popInstr !== memWord(expPc)) begin
                        bad++; $display("FAIL rnd_deq got=%h/%h want=%h/%h", popPcp1, popInstr, expPc + 30'd1, memWord(expPc));
                    end
                    expPc = expPc + 30'd1;
                    pops++;
                end
                prevReq  = reqSeen;
                prevGnt  = gntSeen;
                prevAddr = reqAddr;
            end
        end
        total++; if (pops < 50) begin bad++; $display("FAIL rnd_progress got=%0d want>=50", pops); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_redirect_rsp();
        test_wrap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
